gate_exerciser: RTL and testbench

Self-checking stimulus and response stage for the two-input basic-gate block. It sits directly upstream and downstream of the gate block:
- drives the gate's a/b inputs through all four input combinations;
- samples its six outputs after a programmable settle time;
- compares them against the expected gate functions;
- reports error count, failing-output mask and pass/done status.

The gate block is thereby checked in-system (on a board) instead of only in simulation.

---
 rtl/gate_pkg.sv | 41 ++++
 rtl/gate_golden.sv | 24 ++
 rtl/gate_exerciser.sv | 146 ++++++++++++++
 tb/tb_gate_exerciser.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared encodings for the basic-gate exerciser
//
// Contents: FSM state encoding, Gray-ordered stimulus vector table,
// bit positions of each gate function within the 6-bit output word.
package gate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Stimulus vectors as {a,b}, Gray order so only one input toggles per step
  localparam logic [1:0] VEC0 = 2'b00;
  localparam logic [1:0] VEC1 = 2'b01;
  localparam logic [1:0] VEC2 = 2'b11;
  localparam logic [1:0] VEC3 = 2'b10;

  localparam logic [1:0] LAST_IDX = 2'd3;

  // Bit positions in y: y[0]=y1 .. y[5]=y6
  localparam int Y_AND  = 0;
  localparam int Y_OR   = 1;
  localparam int Y_NAND = 2;
  localparam int Y_NOR  = 3;
  localparam int Y_XOR  = 4;
  localparam int Y_XNOR = 5;

  function automatic logic [1:0] vec_ab(input logic [1:0] idx);
    logic [1:0] v;
    case (idx)
      2'd0:    v = VEC0;
      2'd1:    v = VEC1;
      2'd2:    v = VEC2;
      default: v = VEC3;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/gate_golden.sv
// rtl/gate_golden.sv - combinational reference outputs of the basic-gate block
//
// Ports:
//   a, b   in   gate inputs
//   y_exp  out  expected 6-bit gate output word (AND,OR,NAND,NOR,XOR,XNOR)
module gate_golden
  import gate_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [5:0] y_exp
);

  always_comb begin
    y_exp         = '0;
    y_exp[Y_AND]  = a & b;
    y_exp[Y_OR]   = a | b;
    y_exp[Y_NAND] = ~(a & b);
    y_exp[Y_NOR]  = ~(a | b);
    y_exp[Y_XOR]  = a ^ b;
    y_exp[Y_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - in-system stimulus and checker for the basic-gate block
//
// Parameters:
//   SETTLE    cycles between driving a/b and sampling y (1..15)
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   start     in   begin a check pass (accepted in IDLE or DONE only)
//   a, b      out  registered gate inputs
//   y         in   gate outputs, y[0]=y1 .. y[5]=y6
//   busy      out  pass in progress
//   done      out  pass finished, held until next accepted start or rst
//   pass      out  done with zero mismatches
//   err_cnt   out  total mismatched output bits in the pass
//   err_mask  out  sticky OR of mismatching output bits in the pass
module gate_exerciser
  import gate_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [5:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [5:0] err_mask
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [4:0] err_cnt_nxt;
  logic [5:0] err_mask_nxt;

  logic [5:0] y_exp;
  logic [5:0] mism;
  logic [2:0] mism_cnt;
  logic [4:0] err_sum;

  gate_golden u_golden (
    .a     (a),
    .b     (b),
    .y_exp (y_exp)
  );

  // Max 6 mismatches per vector, 24 per pass, so 5 bits never wraps
  always_comb begin
    mism     = y ^ y_exp;
    mism_cnt = '0;
    for (int i = 0; i < 6; i++) begin
      mism_cnt = mism_cnt + 3'(mism[i]);
    end
    err_sum = err_cnt + 5'(mism_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      err_mask <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      a        <= a_nxt;
      b        <= b_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      pass     <= pass_nxt;
      err_cnt  <= err_cnt_nxt;
      err_mask <= err_mask_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    cnt_nxt      = cnt;
    a_nxt        = a;
    b_nxt        = b;
    busy_nxt     = busy;
    done_nxt     = done;
    pass_nxt     = pass;
    err_cnt_nxt  = err_cnt;
    err_mask_nxt = err_mask;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt      = WAIT;
          idx_nxt        = 2'd0;
          cnt_nxt        = CNT_LOAD;
          {a_nxt, b_nxt} = VEC0;
          busy_nxt       = 1'b1;
          done_nxt       = 1'b0;
          pass_nxt       = 1'b0;
          err_cnt_nxt    = '0;
          err_mask_nxt   = '0;
        end
      end

      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end

      CHECK: begin
        err_cnt_nxt  = err_sum;
        err_mask_nxt = err_mask | mism;
        if (idx != LAST_IDX) begin
          idx_nxt        = idx + 2'd1;
          {a_nxt, b_nxt} = vec_ab(idx + 2'd1);
          cnt_nxt        = CNT_LOAD;
          state_nxt      = WAIT;
        end else begin
          // pass is judged on err_sum so the final vector's result counts
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_sum == 5'd0);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// tb/tb_gate_exerciser.sv - randomized self-checking bench for gate_exerciser
module tb_gate_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start1, start2, sel1;
  logic [5:0] y;

  logic       a2, b2, busy2, done2, pass2;
  logic [4:0] err2;
  logic [5:0] mask2;
  logic       a1, b1, busy1, done1, pass1;
  logic [4:0] err1;
  logic [5:0] mask1;

  gate_exerciser #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .y(y),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .err_mask(mask2)
  );

  gate_exerciser #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .y(y),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .err_mask(mask1)
  );

  // Currently exercised instance
  logic       ca, cb, cbusy, cdone, cpass;
  logic [4:0] cerr;
  logic [5:0] cmask;
  always_comb begin
    if (sel1) {ca, cb, cbusy, cdone, cpass, cerr, cmask} = {a1, b1, busy1, done1, pass1, err1, mask1};
    else      {ca, cb, cbusy, cdone, cpass, cerr, cmask} = {a2, b2, busy2, done2, pass2, err2, mask2};
  end

  // Behavioural gate under test with injectable faults and output delay
  int         delay;
  logic       swp;
  logic [5:0] sa0, sa1;
  logic [5:0] y_comb;
  logic [5:0] pipe [8];

  function automatic logic [5:0] ref_gate(input logic [1:0] ab);
    logic ga, gb;
    ga = ab[1];
    gb = ab[0];
    return {~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ga | gb, ga & gb};
  endfunction

  function automatic logic [5:0] apply_fault(input logic [5:0] g, input logic sw,
                                             input logic [5:0] s0, input logic [5:0] s1);
    logic [5:0] f;
    f = g;
    if (sw) begin
      f[0] = g[2];
      f[2] = g[0];
    end
    return (f & ~s0) | s1;
  endfunction

  always_comb y_comb = apply_fault(ref_gate({ca, cb}), swp, sa0, sa1);

  always_ff @(posedge clk) begin
    pipe[0] <= y_comb;
    for (int j = 1; j < 8; j++) pipe[j] <= pipe[j-1];
  end

  always_comb y = (delay == 0) ? y_comb : pipe[delay-1];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [1:0] last1, last2;

  task automatic run_pass(input bit use1, input int d, input bit sw, input logic [5:0] s0,
                          input logic [5:0] s1, input bit extra, input bit abort,
                          input int lit_err, input int lit_mask);
    int         s, p, off, exp_err;
    logic [5:0] exp_mask, m;
    logic [1:0] vec [4];
    logic [1:0] prev, smp;
    bit         seen_done;
    vec[0] = 2'b00; vec[1] = 2'b01; vec[2] = 2'b11; vec[3] = 2'b10;
    s = use1 ? 1 : 2;
    p = s + 1;
    sel1 = use1; delay = d; swp = sw; sa0 = s0; sa1 = s1;
    repeat (2 * s + 6) @(negedge clk);

    // Reference: y reflects a/b from d cycles back; past SETTLE that is the prior vector
    prev     = use1 ? last1 : last2;
    exp_err  = 0;
    exp_mask = '0;
    for (int i = 0; i < 4; i++) begin
      if (d <= s)      smp = vec[i];
      else if (i == 0) smp = prev;
      else             smp = vec[i-1];
      m        = apply_fault(ref_gate(smp), sw, s0, s1) ^ ref_gate(vec[i]);
      exp_err += $countones(m);
      exp_mask |= m;
    end

    if (use1) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    off = 0;
    chk("accept_busy", cbusy, 1);
    chk("accept_done", cdone, 0);
    chk("accept_pass", cpass, 0);
    chk("accept_err", cerr, 0);
    chk("accept_mask", cmask, 0);
    chk("ab_vec0", {ca, cb}, vec[0]);

    seen_done = 0;
    while (!seen_done && off < 4 * p + 4) begin
      if (extra && off == 2) begin
        if (use1) start1 = 1'b1; else start2 = 1'b1;
      end
      if (abort && off == 3 * p - 1) rst = 1'b1;
      @(negedge clk);
      off++;
      start1 = 1'b0; start2 = 1'b0;
      if (abort && off == 3 * p) begin
        rst = 1'b0;
        chk("abort_busy", cbusy, 0);
        chk("abort_done", cdone, 0);
        chk("abort_err", cerr, 0);
        chk("abort_mask", cmask, 0);
        chk("abort_ab", {ca, cb}, 0);
        last1 = 2'b00; last2 = 2'b00;
        return;
      end
      if (off % p == 0 && off < 4 * p) chk("ab_seq", {ca, cb}, vec[off / p]);
      if (cdone) seen_done = 1;
      else       chk("busy_hold", cbusy, 1);
    end

    chk("done_latency", off, 4 * p);
    chk("done_flag", cdone, 1);
    chk("done_busy", cbusy, 0);
    chk("err_cnt", cerr, exp_err);
    chk("err_mask", cmask, exp_mask);
    chk("pass_flag", cpass, (exp_err == 0) ? 1 : 0);
    chk("ab_hold", {ca, cb}, 2'b10);
    if (lit_err >= 0) begin
      chk("lit_err", cerr, lit_err);
      chk("lit_mask", cmask, lit_mask);
    end
    if (use1) last1 = 2'b10; else last2 = 2'b10;
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; sel1 = 1'b0;
    delay = 0; swp = 1'b0; sa0 = '0; sa1 = '0;
    last1 = 2'b00; last2 = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ab2", {a2, b2}, 0);
    chk("rst_flags2", {busy2, done2, pass2}, 0);
    chk("rst_err2", err2, 0);
    chk("rst_mask2", mask2, 0);
    chk("rst_flags1", {a1, b1, busy1, done1, pass1}, 0);
    chk("rst_res1", {err1, mask1}, 0);

    run_pass(0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 6'b000000);
    run_pass(0, 0, 0, 6'b010000, 6'b000000, 0, 0, 2, 6'b010000);
    run_pass(0, 0, 1, 6'b000000, 6'b000000, 0, 0, 8, 6'b000101);
    run_pass(0, 0, 0, 6'b000000, 6'b000000, 1, 0, 0, 6'b000000);
    run_pass(0, 0, 0, 6'b000000, 6'b000000, 0, 1, -1, 0);
    run_pass(0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 6'b000000);
    run_pass(1, 1, 0, 6'b000000, 6'b000000, 0, 0, 0, 6'b000000);
    run_pass(1, 3, 0, 6'b000000, 6'b000000, 0, 0, -1, 0);
    run_pass(1, 3, 0, 6'b000000, 6'b000000, 0, 0, -1, 0);

    for (int n = 0; n < 30; n++) begin
      bit         u1, ex, sw_r;
      int         d_r;
      logic [5:0] s0_r, s1_r;
      u1   = 1'($urandom_range(0, 1));
      d_r  = $urandom_range(0, u1 ? 3 : 5);
      sw_r = ($urandom_range(0, 3) == 0);
      s0_r = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
      s1_r = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
      ex   = 1'($urandom_range(0, 1));
      run_pass(u1, d_r, sw_r, s0_r, s1_r, ex, ($urandom_range(0, 7) == 0), -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
